mux_serializer: RTL and testbench

- Sequential front/back end for the 16-to-1 mux in the four-bit ALU datapath.
- Accepts a 16-bit word over a valid/ready load handshake, drives it onto the mux data inputs and steps the 4-bit select through every index.
- Samples the mux output each step and emits one bit per index on a valid/ready serial stream.
- Checks each sampled bit against the held word and flags any mux fault.

---
 rtl/mux_serializer_pkg.sv | 29 ++
 rtl/mux_serializer_sel_counter.sv | 44 ++++
 rtl/mux_serializer.sv | 142 ++++++++++++++
 tb/tb_mux_serializer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mux_ser_pkg
//  Brief   : Shared types, defaults and index helpers for the mux serializer.
//  Revision: 1.0 - initial release
// ============================================================================
package mux_ser_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        PRESENT = 2'd2
    } state_t;

    // Select index presented first for a word.
    function automatic int first_index(input bit msb_first, input int width);
        return msb_first ? (width - 1) : 0;
    endfunction

    // Select index presented last for a word; the counter stops here.
    function automatic int final_index(input bit msb_first, input int width);
        return msb_first ? 0 : (width - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_serializer_sel_counter.sv
`default_nettype none
// ============================================================================
//  Module  : mux_sel_counter
//  Brief   : Select counter for the serializer. Loads the first index, steps
//            up or down one index per request and saturates at the final one.
//  Revision: 1.0 - initial release
// ============================================================================
module mux_sel_counter #(
    parameter int          SEL_W = 4,
    parameter int unsigned FIRST = 0,
    parameter int unsigned FINAL = 15,
    parameter bit          DOWN  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    output logic [SEL_W-1:0] count,
    output logic             at_final
);

    localparam logic [SEL_W-1:0] c_FIRST = SEL_W'(FIRST);
    localparam logic [SEL_W-1:0] c_FINAL = SEL_W'(FINAL);
    localparam logic [SEL_W-1:0] c_ONE   = {{(SEL_W-1){1'b0}}, 1'b1};

    logic [SEL_W-1:0] r_count;

    // Load wins over step; a step at the final index is ignored so the
    // select never wraps within a word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= c_FIRST;
        end else if (step && (r_count != c_FINAL)) begin
            r_count <= DOWN ? (r_count - c_ONE) : (r_count + c_ONE);
        end
    end

    assign count    = r_count;
    assign at_final = (r_count == c_FINAL);

endmodule
`default_nettype wire

// File: rtl/mux_serializer.sv
`default_nettype none
// ============================================================================
//  Module  : mux_serializer
//  Brief   : Drives a held word onto an external 16-to-1 mux, walks the select
//            through every index, samples the mux output one bit per index
//            onto a valid/ready serial stream and flags any mux fault.
//  Revision: 1.0 - initial release
// ============================================================================
module mux_serializer
    import mux_ser_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SEL_W     = DEF_SEL_W,   // must equal log2(WIDTH)
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] mux_a,
    output logic [SEL_W-1:0] mux_s,
    input  logic             mux_f,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_bit,
    output logic             ser_last,
    output logic             busy,
    output logic             err
);

    localparam int unsigned c_FIRST_IDX = first_index(MSB_FIRST, WIDTH);
    localparam int unsigned c_FINAL_IDX = final_index(MSB_FIRST, WIDTH);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;
    logic             w_sample;
    logic             w_handshake;
    logic             w_step;
    logic             w_at_final;
    logic [SEL_W-1:0] w_mux_s;

    logic [WIDTH-1:0] r_mux_a;
    logic             r_ser_valid;
    logic             r_ser_bit;
    logic             r_ser_last;
    logic             r_err;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_sample     = 1'b0;
        w_handshake  = 1'b0;
        case (r_state)
            IDLE: begin
                if (load_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = SETTLE;
                end
            end
            SETTLE: begin
                // One cycle lets the mux output settle on the new select.
                w_sample     = 1'b1;
                w_state_next = PRESENT;
            end
            PRESENT: begin
                if (r_ser_valid && ser_ready) begin
                    w_handshake  = 1'b1;
                    w_state_next = r_ser_last ? IDLE : SETTLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_step = w_handshake && !r_ser_last;

    mux_sel_counter #(
        .SEL_W (SEL_W),
        .FIRST (c_FIRST_IDX),
        .FINAL (c_FINAL_IDX),
        .DOWN  (MSB_FIRST)
    ) u_sel_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (w_accept),
        .step     (w_step),
        .count    (w_mux_s),
        .at_final (w_at_final)
    );

    // Word capture, bit sampling, self-check and serial output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mux_a     <= '0;
            r_ser_valid <= 1'b0;
            r_ser_bit   <= 1'b0;
            r_ser_last  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mux_a <= load_data;
                r_err   <= 1'b0;
            end
            if (w_sample) begin
                r_ser_bit   <= mux_f;
                r_ser_valid <= 1'b1;
                r_ser_last  <= w_at_final;
                if (mux_f != r_mux_a[w_mux_s]) begin
                    r_err <= 1'b1;
                end
            end
            if (w_handshake) begin
                r_ser_valid <= 1'b0;
            end
        end
    end

    assign load_ready = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign mux_a      = r_mux_a;
    assign mux_s      = w_mux_s;
    assign ser_valid  = r_ser_valid;
    assign ser_bit    = r_ser_bit;
    assign ser_last   = r_ser_last;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mux_serializer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mux_serializer
//  Brief   : Bench for mux_serializer: one LSB-first and one MSB-first
//            instance, each feeding a behavioural 16-to-1 mux with an
//            optional stuck-at-0 fault on one select value.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_mux_serializer;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        load_valid = '0;
    logic [1:0]        load_ready;
    logic [1:0][15:0]  load_data = '0;
    logic [1:0][15:0]  mux_a;
    logic [1:0][3:0]   mux_s;
    logic [1:0]        mux_f;
    logic [1:0]        ser_valid;
    logic [1:0]        ser_ready = '0;
    logic [1:0]        ser_bit;
    logic [1:0]        ser_last;
    logic [1:0]        busy;
    logic [1:0]        err;
    logic [1:0]        force_en = '0;
    logic [3:0]        force_idx = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Behavioural mux with optional stuck-at-0 on one select value.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            mux_f[i] = (force_en[i] && (mux_s[i] == force_idx)) ? 1'b0 : mux_a[i][mux_s[i]];
        end
    end

    mux_serializer #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .load_valid(load_valid[0]), .load_ready(load_ready[0]), .load_data(load_data[0]),
        .mux_a(mux_a[0]), .mux_s(mux_s[0]), .mux_f(mux_f[0]),
        .ser_valid(ser_valid[0]), .ser_ready(ser_ready[0]), .ser_bit(ser_bit[0]),
        .ser_last(ser_last[0]), .busy(busy[0]), .err(err[0])
    );

    mux_serializer #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst),
        .load_valid(load_valid[1]), .load_ready(load_ready[1]), .load_data(load_data[1]),
        .mux_a(mux_a[1]), .mux_s(mux_s[1]), .mux_f(mux_f[1]),
        .ser_valid(ser_valid[1]), .ser_ready(ser_ready[1]), .ser_bit(ser_bit[1]),
        .ser_last(ser_last[1]), .busy(busy[1]), .err(err[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(input int u);
        chk("rst_mux_a", 32'(mux_a[u]), 32'h0);
        chk("rst_mux_s", 32'(mux_s[u]), 32'h0);
        chk("rst_ser_valid", 32'(ser_valid[u]), 32'h0);
        chk("rst_ser_bit", 32'(ser_bit[u]), 32'h0);
        chk("rst_ser_last", 32'(ser_last[u]), 32'h0);
        chk("rst_busy", 32'(busy[u]), 32'h0);
        chk("rst_err", 32'(err[u]), 32'h0);
        chk("rst_load_ready", 32'(load_ready[u]), 32'h1);
    endtask

    // Present one word and confirm it was taken into SETTLE.
    task automatic do_load(input int u, input logic [15:0] w);
        @(negedge clk);
        chk("load_ready_idle", 32'(load_ready[u]), 32'h1);
        load_valid[u] = 1'b1;
        load_data[u]  = w;
        @(negedge clk);
        load_valid[u] = 1'b0;
        chk("busy_after_load", 32'(busy[u]), 32'h1);
        chk("err_cleared_on_load", 32'(err[u]), 32'h0);
        chk("mux_a_loaded", 32'(mux_a[u]), 32'(w));
        chk("mux_s_first", 32'(mux_s[u]), (u == 1) ? 32'd15 : 32'd0);
        chk("ser_valid_settle", 32'(ser_valid[u]), 32'h0);
    endtask

    // Collect one word's bits and compare against the expected stream
    // (stream[k] = k-th emitted bit). rmode 0: ready always high,
    // rmode 1: ready pattern 1,0,0,1 repeating. fault_pos < 0: no fault.
    // abort_at >= 0: assert rst when bit number abort_at is presented.
    task automatic run_word(input int u, input logic [15:0] stream, input int rmode,
                            input bit hold_load, input int fault_pos, input int abort_at);
        int   hs      = 0;
        bit   done    = 1'b0;
        bit   stalled = 1'b0;
        logic pb      = 1'b0;
        logic pl      = 1'b0;
        logic rdy;
        for (int n = 1; n <= 400 && !done; n++) begin
            @(negedge clk);
            rdy = (rmode == 0) ? 1'b1 : ((n % 4) == 1 || (n % 4) == 0);
            if (stalled) begin
                chk("stall_valid_held", 32'(ser_valid[u]), 32'h1);
                chk("stall_bit_held", 32'(ser_bit[u]), 32'(pb));
                chk("stall_last_held", 32'(ser_last[u]), 32'(pl));
            end
            if (hold_load) chk("load_ready_busy", 32'(load_ready[u]), 32'h0);
            if (abort_at >= 0 && hs == abort_at && ser_valid[u]) begin
                rst          = 1'b1;
                ser_ready[u] = 1'b0;
                done         = 1'b1;
            end else begin
                ser_ready[u] = rdy;
                if (ser_valid[u] && rdy) begin
                    chk("ser_bit", 32'(ser_bit[u]), 32'(stream[hs]));
                    chk("ser_last", 32'(ser_last[u]), (hs == 15) ? 32'h1 : 32'h0);
                    chk("mux_s_step", 32'(mux_s[u]), (u == 1) ? 32'(15 - hs) : 32'(hs));
                    chk("err_flag", 32'(err[u]),
                        (fault_pos >= 0 && hs >= fault_pos) ? 32'h1 : 32'h0);
                    hs++;
                    if (hs == 16) begin
                        if (rmode == 0) chk("word_cycles", 32'(n + 1), 32'd32);
                        chk("load_ready_final_hs", 32'(load_ready[u]), 32'h0);
                        if (hold_load) load_valid[u] = 1'b0;
                        done = 1'b1;
                    end
                end
                stalled = ser_valid[u] && !rdy;
                pb      = ser_bit[u];
                pl      = ser_last[u];
            end
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL run_word_timeout: got %0d handshakes expected 16", hs);
        end else if (abort_at < 0) begin
            @(negedge clk);
            ser_ready[u] = 1'b0;
            chk("busy_after_word", 32'(busy[u]), 32'h0);
            chk("load_ready_after_word", 32'(load_ready[u]), 32'h1);
            chk("ser_valid_after_word", 32'(ser_valid[u]), 32'h0);
        end
    endtask

    typedef struct {
        int          u;
        logic [15:0] word;
        logic [15:0] stream;
        int          rmode;
    } vec_t;

    vec_t tbl[4];

    initial begin
        // Expected streams, bit k = k-th emitted bit, written out by hand.
        tbl[0] = '{u: 0, word: 16'hA5C3, stream: 16'b1010_0101_1100_0011, rmode: 0};
        tbl[1] = '{u: 1, word: 16'h0001, stream: 16'b1000_0000_0000_0000, rmode: 0};
        tbl[2] = '{u: 0, word: 16'hFFFF, stream: 16'b1111_1111_1111_1111, rmode: 1};
        tbl[3] = '{u: 1, word: 16'h00F0, stream: 16'b0000_1111_0000_0000, rmode: 0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_reset_state(0);
        chk_reset_state(1);

        for (int i = 0; i < 4; i++) begin
            do_load(tbl[i].u, tbl[i].word);
            run_word(tbl[i].u, tbl[i].stream, tbl[i].rmode, 1'b0, -1, -1);
        end

        // Load attempt while busy is ignored: output follows the first word.
        do_load(0, 16'h1357);
        load_valid[0] = 1'b1;
        load_data[0]  = 16'h8000;
        run_word(0, 16'h1357, 0, 1'b1, -1, -1);
        chk("mux_a_kept_after_busy_load", 32'(mux_a[0]), 32'h1357);

        // Mux stuck at 0 on select 5 for a word with only bit 5 set.
        force_idx   = 4'd5;
        force_en[0] = 1'b1;
        do_load(0, 16'h0020);
        run_word(0, 16'h0000, 0, 1'b0, 5, -1);
        force_en[0] = 1'b0;
        chk("err_sticky", 32'(err[0]), 32'h1);
        // The next accepted load clears err (checked inside do_load).
        do_load(0, 16'h0F0F);
        run_word(0, 16'h0F0F, 0, 1'b0, -1, -1);

        // Reset in the middle of a word, then a clean word from index 0.
        do_load(0, 16'h1234);
        run_word(0, 16'h1234, 0, 1'b0, -1, 7);
        @(negedge clk);
        chk_reset_state(0);
        rst = 1'b0;
        do_load(0, 16'h00FF);
        run_word(0, 16'h00FF, 0, 1'b0, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
